// File: rtl/display_pkg.sv
// Shared types and constants for the display request arbiter.
// Holds the FSM state encoding and the round-robin pointer wrap helper.
package display_pkg;

    localparam int DISP_W    = 32;
    localparam int REQ_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    // Next round-robin start index after idx, wrapping at n requesters.
    function automatic logic [REQ_IDX_W-1:0] wrap_inc(input logic [REQ_IDX_W-1:0] idx,
                                                      input int n);
        logic [REQ_IDX_W-1:0] nxt;
        if (idx == REQ_IDX_W'(n - 1)) begin
            nxt = {REQ_IDX_W{1'b0}};
        end else begin
            nxt = idx + REQ_IDX_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Produces the one-hot winner, its index and an any-request flag.
module rr_pick
    import display_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [REQ_IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0]   win_oh,
    output logic [REQ_IDX_W-1:0] win_idx,
    output logic                 any
);

    // Scan priority slots k = 0..NUM_REQ-1 starting from ptr; first hit wins.
    always_comb begin : pick
        logic hit_s;
        win_oh  = {NUM_REQ{1'b0}};
        win_idx = {REQ_IDX_W{1'b0}};
        any     = 1'b0;
        hit_s   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hit_s     = !any && req[i] && (i == ((int'(ptr) + k) % NUM_REQ));
                win_oh[i] = win_oh[i] | hit_s;
                win_idx   = hit_s ? REQ_IDX_W'(i) : win_idx;
                any       = any | hit_s;
            end
        end
    end

endmodule

// File: rtl/display_request_arbiter.sv
// Round-robin owner arbitration for the shared seven-segment display, with a
// minimum hold per grant and a one-cycle blank gap between owners.
module display_request_arbiter
    import display_pkg::*;
#(
    parameter int                NUM_REQ     = 4,
    parameter int                HOLD_CYCLES = 1024,
    parameter logic [DISP_W-1:0] IDLE_VALUE  = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DISP_W*NUM_REQ-1:0] value,
    output logic [NUM_REQ-1:0]        grant,
    output logic [REQ_IDX_W-1:0]      owner_id,
    output logic                      busy,
    output logic [DISP_W-1:0]         number
);

    localparam int                HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    arb_state_e             state_r, state_s;
    logic [NUM_REQ-1:0]     grant_r, grant_s;
    logic [REQ_IDX_W-1:0]   owner_r, owner_s;
    logic                   busy_r, busy_s;
    logic [DISP_W-1:0]      number_r, number_s;
    logic [HOLD_W-1:0]      hold_r, hold_s;
    logic [REQ_IDX_W-1:0]   ptr_r, ptr_s;

    logic [NUM_REQ-1:0]     pick_oh_s;
    logic [REQ_IDX_W-1:0]   pick_idx_s;
    logic                   pick_any_s;
    logic [DISP_W-1:0]      owner_val_s;
    logic                   owner_req_s;
    logic                   others_req_s;
    logic                   held_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_r),
        .win_oh  (pick_oh_s),
        .win_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    // Owner status and value slice, selected by the one-hot grant.
    always_comb begin
        owner_val_s = {DISP_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_val_s = grant_r[i] ? value[i*DISP_W +: DISP_W] : owner_val_s;
        end
        owner_req_s  = |(req & grant_r);
        others_req_s = |(req & ~grant_r);
        held_s       = (hold_r == HOLD_MAX);
    end

    // Next-state and next-output logic for the IDLE/OWN/GAP arbiter.
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        owner_s  = owner_r;
        busy_s   = busy_r;
        number_s = number_r;
        hold_s   = hold_r;
        ptr_s    = ptr_r;
        case (state_r)
            IDLE, GAP: begin
                if (pick_any_s) begin
                    state_s  = OWN;
                    grant_s  = pick_oh_s;
                    owner_s  = pick_idx_s;
                    busy_s   = 1'b1;
                    hold_s   = {HOLD_W{1'b0}};
                    ptr_s    = wrap_inc(pick_idx_s, NUM_REQ);
                    number_s = IDLE_VALUE;
                end else begin
                    state_s  = IDLE;
                    grant_s  = {NUM_REQ{1'b0}};
                    busy_s   = 1'b0;
                    number_s = IDLE_VALUE;
                end
            end
            OWN: begin
                // Early release is always honoured; preemption only once held.
                if (!owner_req_s || (held_s && others_req_s)) begin
                    state_s  = GAP;
                    grant_s  = {NUM_REQ{1'b0}};
                    busy_s   = 1'b0;
                    number_s = IDLE_VALUE;
                end else begin
                    number_s = owner_val_s;
                    hold_s   = held_s ? hold_r : hold_r + HOLD_W'(1);
                end
            end
            default: begin
                state_s  = IDLE;
                grant_s  = {NUM_REQ{1'b0}};
                busy_s   = 1'b0;
                number_s = IDLE_VALUE;
                hold_s   = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State, counter, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            grant_r  <= {NUM_REQ{1'b0}};
            owner_r  <= {REQ_IDX_W{1'b0}};
            busy_r   <= 1'b0;
            number_r <= IDLE_VALUE;
            hold_r   <= {HOLD_W{1'b0}};
            ptr_r    <= {REQ_IDX_W{1'b0}};
        end else begin
            state_r  <= state_s;
            grant_r  <= grant_s;
            owner_r  <= owner_s;
            busy_r   <= busy_s;
            number_r <= number_s;
            hold_r   <= hold_s;
            ptr_r    <= ptr_s;
        end
    end

    assign grant    = grant_r;
    assign owner_id = owner_r;
    assign busy     = busy_r;
    assign number   = number_r;

endmodule
